mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the processor's data-access interface. Accepts one load/store request at a time from the datapath-side initiator over a valid/ready handshake. Services it against an internal word-organised RAM after a programmable number of wait states, and returns read data plus an error flag over a second valid/ready handshake. It sits between the core's address/write-data outputs and its read-data input when the memory is not single-cycle.

## Interface
- `DEPTH_WORDS`, 64: RAM size in 32-bit words; power of two, ≥4.
- `LATENCY`, 2: wait-state cycles between acceptance and response; 0–15.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset asserted, sampled on `clk`).
- `req_valid`  in  1  initiator presents a request.
- `req_ready`  out  1  responder can accept; reset value 1.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables, bit i ↔ bits [8i+7:8i]; present only with `MEM_RESPONDER_BYTE_EN`.
- `rsp_valid`  out  1  response available; reset value 0.
- `rsp_ready`  in  1  initiator takes response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors; reset value 0.
- `rsp_err`  out  1  request was misaligned or out of range; reset value 0.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`:
  - latch we/addr/wdata(/be);
  - load the wait counter with `LATENCY`;
  - go to WAIT, or directly to RESP when `LATENCY`=0.
- WAIT: `req_ready`=0. The counter decrements each cycle; when it reaches 1, the next state is RESP. Exactly `LATENCY` cycles are spent in WAIT.
- Access is performed on the edge entering RESP:
  - Error when `addr[1:0]`≠0 or word index `addr>>2` ≥ `DEPTH_WORDS`. On error: no write, `rsp_rdata`=0, `rsp_err`=1.
  - Store: write `RAM[addr>>2]` (whole word, or enabled bytes). `rsp_rdata`=0, `rsp_err`=0.
  - Load: `rsp_rdata`=`RAM[addr>>2]`, `rsp_err`=0.
- RESP: `rsp_valid`=1, `req_ready`=0. `rsp_rdata` and `rsp_err` are held stable until `rsp_ready`=1, then go to IDLE. `rsp_valid` drops on the following cycle.
- One outstanding request at most; no request is accepted in WAIT or RESP.
- Back-pressure: `rsp_ready` held low keeps the block in RESP indefinitely with outputs stable.
- Reset mid-operation: returns to IDLE. The in-flight request is discarded (its write is not performed if still in WAIT). Response outputs return to reset values. RAM contents are not cleared by reset.
- Store then load to the same word returns the stored data.
- Address bits above the index are ignored only via the range check. There is no aliasing: an out-of-range address always errors.

## Timing
- Acceptance edge = cycle 0. `rsp_valid` rises in cycle `LATENCY`+1.
- With `rsp_ready` tied high: one access per `LATENCY`+2 cycles; `req_ready` is high again in cycle `LATENCY`+2.
- `req_ready` and `rsp_valid` are registered-state decodes, never combinational from inputs.
- `req_*` inputs are sampled only on the acceptance edge; later changes are ignored.

## Configuration
- `MEM_RESPONDER_BYTE_EN` defined: the `req_be` port exists. Stores update only enabled bytes; `req_be`=0 is a legal no-op store with `rsp_err`=0. Loads ignore `req_be` and return the full word.
- Undefined: no `req_be` port; every store writes all 4 bytes.

## Structure
- Package `mem_responder_pkg`: state enum (IDLE, WAIT, RESP), wait-counter width constant (4 bits), byte-enable width constant.
- Sub-module `mem_responder_ram`:
  - `DEPTH_WORDS`×32 array;
  - synchronous write with per-byte enables (all-ones when the macro is off);
  - combinational read.
- The FSM, counter and range check live in the top.

## Test plan
- Reset, then `LATENCY`=2: store 0xDEADBEEF at 0x10, `rsp_ready`=1 → `rsp_valid` in cycle 3, `rsp_err`=0. Then load 0x10 → `rsp_rdata`=0xDEADBEEF.
- Load from 0x0000_0006 (misaligned) → `rsp_err`=1, `rsp_rdata`=0. Store to 0x100 with `DEPTH_WORDS`=64 → `rsp_err`=1, and a load of word 0 is unchanged.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` and `rsp_err` stable, `req_ready`=0, a concurrent `req_valid` is ignored.
- `LATENCY`=0: back-to-back store/load to 0x4 → response one cycle after each acceptance, throughput one access per 2 cycles.
- Assert `reset`=0 during WAIT of a store to 0x8 (old value 0x11111111) → IDLE, `rsp_valid`=0, a later load of 0x8 returns 0x11111111.
- With `MEM_RESPONDER_BYTE_EN`: word 0x20 = 0xAABBCCDD, store 0x11223344 with `req_be`=4'b0101 → load returns 0xAA22CC44.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the mem_responder request/response block.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W  = 4;
  localparam int BE_W   = 4;
  localparam int WORD_W = 32;

endpackage

// File: rtl/mem_responder_ram.sv
// Word-organised RAM: synchronous byte-enabled write, combinational read.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           i_we,
  input  logic [BE_W-1:0]                i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [WORD_W-1:0]              i_wdata,
  output logic [WORD_W-1:0]              o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with LATENCY wait states.
// Define MEM_RESPONDER_BYTE_EN to add the req_be port and per-byte stores.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
`ifdef MEM_RESPONDER_BYTE_EN
  input  logic [BE_W-1:0]   req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int               AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(LATENCY);
  localparam bit               ZERO_LAT = (LATENCY == 0);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_fire;
  logic              w_a_we;
  logic [31:0]       w_a_addr;
  logic [31:0]       w_a_wdata;
  logic [BE_W-1:0]   w_a_be;
  logic              w_err;
  logic              w_ram_we;
  logic [31:0]       w_ram_rdata;
  logic [31:0]       w_rsp_rdata;

  assign w_accept = req_valid && r_req_ready;

  // With zero latency the access happens on the acceptance edge, so use live inputs.
  assign w_a_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_a_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_a_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

`ifdef MEM_RESPONDER_BYTE_EN
  logic [BE_W-1:0] r_be;
  assign w_a_be = (r_state == IDLE) ? req_be : r_be;
  always_ff @(posedge clk) begin
    if (w_accept) r_be <= req_be;
  end
`else
  assign w_a_be = '1;
`endif

  assign w_err = (|w_a_addr[1:0]) || (|w_a_addr[31:AW+2]);

  assign w_fire = reset &&
                  (((r_state == IDLE) && w_accept && ZERO_LAT) ||
                   ((r_state == WAIT) && (r_cnt == CNT_W'(1))));

  assign w_ram_we    = w_fire && w_a_we && !w_err;
  assign w_rsp_rdata = (w_a_we || w_err) ? 32'd0 : w_ram_rdata;

  mem_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_be    (w_a_be),
    .i_addr  (w_a_addr[AW+1:2]),
    .i_wdata (w_a_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= LAT_C;
            r_req_ready <= 1'b0;
            if (ZERO_LAT) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= w_rsp_rdata;
              r_err       <= w_err;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_rsp_rdata;
            r_err       <= w_err;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_rdata     <= '0;
            r_err       <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 and one LATENCY=0 instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;
  bit          sel;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic        c_req_ready, c_rsp_valid, c_rsp_err;
  logic [31:0] c_rsp_rdata;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign a_req_valid = req_valid && !sel;
  assign b_req_valid = req_valid && sel;
  assign c_req_ready = sel ? b_req_ready : a_req_ready;
  assign c_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign c_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign c_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_l2 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_RESPONDER_BYTE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_l0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_RESPONDER_BYTE_EN
    .req_be    (req_be),
`endif
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request/response with rsp_ready high; checks latency and handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [31:0] exp_rdata,
                     input logic exp_err, input string tag);
    int lat;
    lat = sel ? 0 : 2;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    check({tag, ".req_ready"}, {31'd0, c_req_ready}, 32'd1);
    tick;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = ~wdata;
    req_be    = ~be;
    for (int i = 0; i < lat; i++) begin
      check({tag, ".wait_vld"}, {31'd0, c_rsp_valid}, 32'd0);
      check({tag, ".wait_rdy"}, {31'd0, c_req_ready}, 32'd0);
      tick;
    end
    check({tag, ".rsp_valid"}, {31'd0, c_rsp_valid}, 32'd1);
    check({tag, ".rsp_rdata"}, c_rsp_rdata, exp_rdata);
    check({tag, ".rsp_err"},   {31'd0, c_rsp_err}, {31'd0, exp_err});
    check({tag, ".resp_rdy"},  {31'd0, c_req_ready}, 32'd0);
    tick;
    check({tag, ".done_vld"}, {31'd0, c_rsp_valid}, 32'd0);
    check({tag, ".done_rdy"}, {31'd0, c_req_ready}, 32'd1);
  endtask

  initial begin
    sel       = 1'b0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = 4'hF;
    rsp_ready = 1'b1;
    repeat (3) tick;

    check("rst.a_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rst.a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rst.a_rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst.a_rsp_err",   {31'd0, a_rsp_err}, 32'd0);
    check("rst.b_req_ready", {31'd0, b_req_ready}, 32'd1);
    check("rst.b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    reset = 1'b1;
    tick;

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, "st10");
    txn(1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, "ld10");

    txn(1'b1, 32'h0, 32'h55AA_00FF, 4'hF, 32'd0, 1'b0, "st0");
    txn(1'b0, 32'h6, 32'd0, 4'hF, 32'd0, 1'b1, "ld_misal");
    txn(1'b1, 32'h2, 32'h0BAD_0BAD, 4'hF, 32'd0, 1'b1, "st_misal");
    txn(1'b1, 32'h100, 32'h1234_5678, 4'hF, 32'd0, 1'b1, "st_oor");
    txn(1'b0, 32'h8000_0000, 32'd0, 4'hF, 32'd0, 1'b1, "ld_oor_hi");
    txn(1'b0, 32'h0, 32'd0, 4'hF, 32'h55AA_00FF, 1'b0, "ld0_after_oor");
    txn(1'b1, 32'hFC, 32'hA5A5_5A5A, 4'hF, 32'd0, 1'b0, "st_last");
    txn(1'b0, 32'hFC, 32'd0, 4'hF, 32'hA5A5_5A5A, 1'b0, "ld_last");
    txn(1'b0, 32'h0, 32'd0, 4'hF, 32'h55AA_00FF, 1'b0, "ld0_after_last");

    // Back-pressure: hold the load response for five cycles.
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h0000_0000;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp.rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
      check("bp.rsp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
      check("bp.rsp_err",   {31'd0, a_rsp_err}, 32'd0);
      check("bp.req_ready", {31'd0, a_req_ready}, 32'd0);
      tick;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    check("bp.release_vld", {31'd0, a_rsp_valid}, 32'd0);
    check("bp.release_rdy", {31'd0, a_req_ready}, 32'd1);
    txn(1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, "ld10_after_bp");

    // Reset lands on the edge that would have performed the store.
    txn(1'b1, 32'h8, 32'h1111_1111, 4'hF, 32'd0, 1'b0, "st8");
    req_we    = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'h2222_2222;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    check("rstw.rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rstw.req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rstw.rsp_rdata", a_rsp_rdata, 32'd0);
    check("rstw.rsp_err",   {31'd0, a_rsp_err}, 32'd0);
    reset = 1'b1;
    tick;
    txn(1'b0, 32'h8, 32'd0, 4'hF, 32'h1111_1111, 1'b0, "ld8_after_rst");

    // Zero-latency instance, back-to-back accesses.
    sel = 1'b1;
    txn(1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, "l0.st4");
    txn(1'b0, 32'h4, 32'd0, 4'hF, 32'hCAFE_F00D, 1'b0, "l0.ld4");
    txn(1'b0, 32'h5, 32'd0, 4'hF, 32'd0, 1'b1, "l0.ld_misal");
    txn(1'b1, 32'h4, 32'h0102_0304, 4'hF, 32'd0, 1'b0, "l0.st4b");
    txn(1'b0, 32'h4, 32'd0, 4'hF, 32'h0102_0304, 1'b0, "l0.ld4b");
    sel = 1'b0;

`ifdef MEM_RESPONDER_BYTE_EN
    txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, 32'd0, 1'b0, "be.full");
    txn(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 32'd0, 1'b0, "be.0101");
    txn(1'b0, 32'h20, 32'd0, 4'b0000, 32'hAA22_CC44, 1'b0, "be.ld");
    txn(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, "be.none");
    txn(1'b0, 32'h20, 32'd0, 4'hF, 32'hAA22_CC44, 1'b0, "be.ld2");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
